image_unblend1: RTL and testbench

- Streaming decoder for the 50% two-image RGB blend, which computes out = (img1*0x80)[15:8] + (img2*0x80)[15:8] using the approximate multiplier1.
- Takes a blended pixel and the matching known img2 pixel, and reconstructs img1 = 2*(out − (img2*0x80)[15:8]) with saturation.
- Uses the same multiplier1, so the approximation error of the img2 term cancels.
- Sits between the blended-image memory reader and the output writer. Valid/ready streaming on both sides, with frame-position tracking.

---
 rtl/image_pkg.sv | 22 ++
 rtl/multiplier1.sv | 21 ++
 rtl/image_unblend1.sv | 108 ++++++++++
 tb/tb_image_unblend1.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/image_pkg.sv
// Shared pixel-path definitions for the two-image 50% blend encoder and decoder.
// clamp_recon turns the signed blend-minus-reference difference into {sat, pixel}.
package image_pkg;

  localparam int PIX_W          = 8;
  localparam int DEFAULT_PIXELS = 270000;
  localparam int DEFAULT_CNT_W  = 19;
  localparam logic [PIX_W-1:0] ALPHA_HALF = 8'h80;

  // The halved img1 term doubles back to a pixel; anything outside 0..127 clamps.
  function automatic logic [PIX_W:0] clamp_recon(input logic signed [PIX_W:0] d);
    logic [PIX_W:0] r;
    if (d < 0)
      r = {1'b1, 8'h00};
    else if (d > 9'sd127)
      r = {1'b1, 8'hFF};
    else
      r = {1'b0, d[6:0], 1'b0};
    return r;
  endfunction

endpackage

// File: rtl/multiplier1.sv
// Approximate 8x8 unsigned multiplier: partial-product bits in the lowest
// columns are dropped. A single-bit multiplicand (e.g. 8'h80) stays exact.
module multiplier1 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] y
);

  localparam int TRUNC = 6;

  always_comb begin
    y = '0;
    for (int i = 0; i < 8; i++) begin
      for (int j = 0; j < 8; j++) begin
        if (i + j >= TRUNC)
          y = y + ({15'b0, a[i] & b[j]} << (i + j));
      end
    end
  end

endmodule

// File: rtl/image_unblend1.sv
// Streaming 50% blend decoder: img1 = 2*(blend - (img2*ALPHA)[15:8]) with clamping.
// Two-stage valid/ready pipeline with frame index, last flag and clamp statistics.
module image_unblend1
  import image_pkg::*;
#(
  parameter int PIXELS = DEFAULT_PIXELS,
  parameter int CNT_W  = DEFAULT_CNT_W,
  parameter logic [PIX_W-1:0] ALPHA = ALPHA_HALF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_blend,
  input  logic [PIX_W-1:0] in_ref,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_last,
  output logic [CNT_W-1:0] out_index,
  output logic [15:0]      sat_count,
  output logic             frame_done
);

  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(PIXELS - 1);

  logic             s1_valid;
  logic [PIX_W-1:0] s1_blend;
  logic [PIX_W-1:0] s1_p;
  logic [CNT_W-1:0] s1_idx;
  logic [CNT_W-1:0] in_cnt;
  logic             out_sat;
  logic [15:0]      prod;
  logic             prod_lo_unused;
  logic             s2_adv;
  logic             in_xfer;
  logic             out_xfer;
  logic [PIX_W:0]   recon;

  // Same approximate multiplier as the encoder, so its error on the img2 term cancels.
  multiplier1 u_mult (
    .a (ALPHA),
    .b (in_ref),
    .y (prod)
  );

  assign prod_lo_unused = ^prod[7:0];

  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !rst && (!s1_valid || s2_adv);
  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;
  assign recon    = clamp_recon($signed({1'b0, s1_blend}) - $signed({1'b0, s1_p}));

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_blend <= '0;
      s1_p     <= '0;
      s1_idx   <= '0;
      in_cnt   <= '0;
    end else begin
      if (in_ready)
        s1_valid <= in_valid;
      if (in_xfer) begin
        s1_blend <= in_blend;
        s1_p     <= prod[15:8];
        s1_idx   <= in_cnt;
        in_cnt   <= (in_cnt == LAST_IDX) ? '0 : in_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_pixel <= '0;
      out_last  <= 1'b0;
      out_index <= '0;
      out_sat   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_pixel <= recon[PIX_W-1:0];
        out_sat   <= recon[PIX_W];
        out_index <= s1_idx;
        out_last  <= (s1_idx == LAST_IDX);
      end
    end
  end

  // End of frame clears the clamp count even when the last pixel itself clamped.
  always_ff @(posedge clk) begin
    if (rst) begin
      sat_count  <= '0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= out_xfer && out_last;
      if (out_xfer) begin
        if (out_last)
          sat_count <= '0;
        else if (out_sat && sat_count != 16'hFFFF)
          sat_count <= sat_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_image_unblend1.sv
// Randomized bench for image_unblend1 with a small frame (8 pixels) and a
// queue-based reference model of decode, indexing and clamp statistics.
module tb_image_unblend1;

  localparam int TB_PIXELS = 8;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_blend;
  logic [7:0]  in_ref;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_pixel;
  logic        out_last;
  logic [18:0] out_index;
  logic [15:0] sat_count;
  logic        frame_done;

  image_unblend1 #(.PIXELS(TB_PIXELS), .CNT_W(19)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_blend   (in_blend),
    .in_ref     (in_ref),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_pixel  (out_pixel),
    .out_last   (out_last),
    .out_index  (out_index),
    .sat_count  (sat_count),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] pix;
    logic       sat;
    int         idx;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   in_cnt   = 0;
  int   exp_sat  = 0;
  logic exp_fd   = 1'b0;
  logic prev_rst = 1'b0;
  logic armed    = 1'b0;
  int   fd_cnt   = 0;
  int   or_mode  = 0;
  int   pat      = 0;
  logic [7:0] drv_pix = 8'h00;
  logic       drv_sat = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // (img*0x80)[15:8] is simply half the pixel, rounded down
  function automatic int half_of(input int x);
    return (x * 128) / 256;
  endfunction

  function automatic logic [8:0] decode_model(input int blend, input int ref_pix);
    int diff;
    diff = blend - half_of(ref_pix);
    if (diff < 0)   return {1'b1, 8'h00};
    if (diff > 127) return {1'b1, 8'hFF};
    return {1'b0, 8'(diff * 2)};
  endfunction

  always @(posedge clk) begin
    #1;
    case (or_mode)
      0: out_ready = 1'b1;
      1: out_ready = ($urandom_range(0, 3) != 0);
      default: begin
        out_ready = (pat == 0);
        pat = (pat + 1) % 3;
      end
    endcase
  end

  always @(negedge clk) begin
    exp_t e;
    logic nfd;
    nfd = 1'b0;
    if (prev_rst) begin
      armed = 1'b1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_index", out_index, 0);
      chk("rst_out_pixel", out_pixel, 8'h00);
      chk("rst_out_last", out_last, 1'b0);
    end
    if (armed) begin
      chk("sat_count", sat_count, exp_sat);
      chk("frame_done", frame_done, exp_fd);
      if (frame_done) fd_cnt++;
    end
    if (rst) begin
      chk("rst_in_ready", in_ready, 1'b0);
      q.delete();
      in_cnt = 0;
      exp_sat = 0;
    end else if (armed) begin
      if (out_valid && q.size() == 0)
        chk("out_spurious", out_valid, 1'b0);
      else if (out_valid) begin
        e = q[0];
        chk("out_pixel", out_pixel, e.pix);
        chk("out_index", out_index, e.idx);
        chk("out_last", out_last, e.idx == TB_PIXELS - 1);
        if (out_ready) begin
          void'(q.pop_front());
          if (e.idx == TB_PIXELS - 1) begin
            exp_sat = 0;
            nfd = 1'b1;
          end else if (e.sat && exp_sat < 65535) exp_sat++;
        end
      end
      if (in_valid && in_ready) begin
        e.pix = drv_pix;
        e.sat = drv_sat;
        e.idx = in_cnt;
        q.push_back(e);
        in_cnt = (in_cnt + 1) % TB_PIXELS;
      end
    end
    exp_fd = nfd;
    prev_rst = rst;
  end

  task automatic send_pair(input logic [7:0] b, input logic [7:0] r,
                           input logic [7:0] ep, input logic es);
    int waited;
    in_blend = b;
    in_ref   = r;
    drv_pix  = ep;
    drv_sat  = es;
    in_valid = 1'b1;
    waited   = 0;
    @(negedge clk);
    while (!in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) chk("in_timeout", in_ready, 1'b1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_model(input logic [7:0] b, input logic [7:0] r);
    logic [8:0] m;
    m = decode_model(int'(b), int'(r));
    send_pair(b, r, m[7:0], m[8]);
  endtask

  task automatic drain();
    int n;
    or_mode = 0;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int lat;
    int fd_start;
    logic [7:0] a;
    logic [7:0] b;
    rst = 1'b1;
    in_valid = 1'b1;
    in_blend = 8'h00;
    in_ref = 8'h00;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    in_valid = 1'b0;
    @(posedge clk);
    #1;

    // zero reference, first index and 2-cycle latency
    send_pair(8'h7F, 8'h00, 8'hFE, 1'b0);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", lat, 2);
    chk("first_index", out_index, 0);
    chk("zero_ref_pix", out_pixel, 8'hFE);
    send_pair(8'h80, 8'h00, 8'hFF, 1'b1);
    send_pair(8'h00, 8'hFF, 8'h00, 1'b1);
    drain();
    chk("sat_two", sat_count, 2);

    // round trip through the encoder with random pacing on both sides
    or_mode = 1;
    for (int i = 0; i < 1000; i++) begin
      a = 8'($urandom_range(0, 127) * 2);
      b = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk);
        #1;
      end
      send_pair(8'(half_of(int'(a)) + half_of(int'(b))), b, a, 1'b0);
    end
    drain();

    // 1,0,0 back-pressure, clamped pixel placed at each frame end
    pulse_reset();
    or_mode = 2;
    pat = 0;
    for (int i = 0; i < 20; i++) begin
      if (i % TB_PIXELS == TB_PIXELS - 1) send_model(8'h00, 8'hFF);
      else send_model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    end
    drain();

    // frame boundary with 10 pairs, one frame_done pulse expected
    pulse_reset();
    fd_start = fd_cnt;
    for (int i = 0; i < 10; i++)
      send_model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    drain();
    chk("frame_done_count", fd_cnt - fd_start, 1);

    // reset while pixels are in flight
    pulse_reset();
    for (int i = 0; i < 5; i++)
      send_model(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
    chk("midrst_busy", out_valid, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_drop", out_valid, 1'b0);
    send_model(8'h40, 8'h10);
    lat = 1;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("midrst_latency", lat, 2);
    chk("midrst_index", out_index, 0);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
